// File: rtl/reg_access_if.sv
// Bundles the issue, operand, register-file and writeback buses of reg_access.
// master drives the DUT inputs (decode/execute/RF side); slave is the reg_access side.
interface reg_access_if;
    logic        iss_valid;
    logic        iss_ready;
    logic        iss_rden1;
    logic [4:0]  iss_rs1;
    logic        iss_rden2;
    logic [4:0]  iss_rs2;
    logic        iss_wren;
    logic [4:0]  iss_rd;

    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_rdata1;
    logic [31:0] op_rdata2;
    logic [4:0]  op_rd;

    logic        rf_rden1;
    logic [4:0]  rf_raddr1;
    logic [31:0] rf_rdata1;
    logic        rf_rden2;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata2;
    logic        rf_wren;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic        alu_wb_valid;
    logic [4:0]  alu_wb_addr;
    logic [31:0] alu_wb_data;

    logic        lng_wb_valid;
    logic        lng_wb_ready;
    logic [4:0]  lng_wb_addr;
    logic [31:0] lng_wb_data;

    modport master (
        output iss_valid, iss_rden1, iss_rs1, iss_rden2, iss_rs2, iss_wren, iss_rd,
        input  iss_ready,
        input  op_valid, op_rdata1, op_rdata2, op_rd,
        output op_ready,
        input  rf_rden1, rf_raddr1, rf_rden2, rf_raddr2, rf_wren, rf_waddr, rf_wdata,
        output rf_rdata1, rf_rdata2,
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output lng_wb_valid, lng_wb_addr, lng_wb_data,
        input  lng_wb_ready
    );

    modport slave (
        input  iss_valid, iss_rden1, iss_rs1, iss_rden2, iss_rs2, iss_wren, iss_rd,
        output iss_ready,
        output op_valid, op_rdata1, op_rdata2, op_rd,
        input  op_ready,
        output rf_rden1, rf_raddr1, rf_rden2, rf_raddr2, rf_wren, rf_waddr, rf_wdata,
        input  rf_rdata1, rf_rdata2,
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  lng_wb_valid, lng_wb_addr, lng_wb_data,
        output lng_wb_ready
    );
endinterface

// File: rtl/reg_access.sv
// Operand fetch stage between decode and execute: RF reads with write forwarding,
// destination scoreboard, and a single write port shared by ALU and long-latency writebacks.
module reg_access #(
    parameter int LQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    reg_access_if.slave bus
);
    localparam int            PW      = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam logic [PW:0]   CNT_MAX = LQ_DEPTH[PW:0];
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [4:0]    lq_addr_q [LQ_DEPTH];
    logic [31:0]   lq_data_q [LQ_DEPTH];
    logic [PW-1:0] lq_wptr_q, lq_rptr_q;
    logic [PW:0]   lq_cnt_q, lq_cnt_d;
    logic [31:0]   busy_q, busy_d;
    logic          op_valid_q;
    logic [31:0]   op_rdata1_q, op_rdata2_q;
    logic [4:0]    op_rd_q;

    logic        lq_empty, lq_full, lq_push, lq_pop;
    logic        wr_sel, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        fwd1, fwd2;
    logic [31:0] opnd1, opnd2;
    logic        haz_rs1, haz_rs2, haz_rd;
    logic        iss_rdy, accept;
    logic [31:0] busy_clr, busy_set;

    assign lq_empty = (lq_cnt_q == '0);
    assign lq_full  = (lq_cnt_q == CNT_MAX);
    assign lq_push  = bus.lng_wb_valid && !lq_full;
    // ALU writeback owns the port whenever valid, even when its address is x0.
    assign lq_pop   = !bus.alu_wb_valid && !lq_empty;

    assign wr_sel  = bus.alu_wb_valid || !lq_empty;
    assign wr_addr = bus.alu_wb_valid ? bus.alu_wb_addr : lq_addr_q[lq_rptr_q];
    assign wr_data = bus.alu_wb_valid ? bus.alu_wb_data : lq_data_q[lq_rptr_q];
    assign wr_en   = !rst && wr_sel && (wr_addr != 5'd0);

    assign bus.rf_wren      = wr_en;
    assign bus.rf_waddr     = wr_addr;
    assign bus.rf_wdata     = wr_data;
    assign bus.lng_wb_ready = !lq_full;

    assign bus.rf_rden1  = bus.iss_valid && bus.iss_rden1;
    assign bus.rf_raddr1 = bus.iss_rs1;
    assign bus.rf_rden2  = bus.iss_valid && bus.iss_rden2;
    assign bus.rf_raddr2 = bus.iss_rs2;

    assign fwd1  = wr_en && (wr_addr == bus.iss_rs1) && (bus.iss_rs1 != 5'd0);
    assign fwd2  = wr_en && (wr_addr == bus.iss_rs2) && (bus.iss_rs2 != 5'd0);
    assign opnd1 = !bus.iss_rden1 ? 32'd0 : (fwd1 ? wr_data : bus.rf_rdata1);
    assign opnd2 = !bus.iss_rden2 ? 32'd0 : (fwd2 ? wr_data : bus.rf_rdata2);

    // A pending register whose write commits this cycle no longer blocks issue.
    assign haz_rs1 = bus.iss_rden1 && busy_q[bus.iss_rs1] && !(wr_en && wr_addr == bus.iss_rs1);
    assign haz_rs2 = bus.iss_rden2 && busy_q[bus.iss_rs2] && !(wr_en && wr_addr == bus.iss_rs2);
    assign haz_rd  = bus.iss_wren  && busy_q[bus.iss_rd]  && !(wr_en && wr_addr == bus.iss_rd);

    assign iss_rdy       = (!op_valid_q || bus.op_ready) && !(haz_rs1 || haz_rs2 || haz_rd);
    assign accept        = bus.iss_valid && iss_rdy;
    assign bus.iss_ready = iss_rdy;

    assign bus.op_valid  = op_valid_q;
    assign bus.op_rdata1 = op_rdata1_q;
    assign bus.op_rdata2 = op_rdata2_q;
    assign bus.op_rd     = op_rd_q;

    always_comb begin
        busy_clr  = wr_en ? (32'd1 << wr_addr) : 32'd0;
        busy_set  = (accept && bus.iss_wren && bus.iss_rd != 5'd0) ? (32'd1 << bus.iss_rd) : 32'd0;
        busy_d    = (busy_q & ~busy_clr) | busy_set;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        lq_cnt_d = lq_cnt_q;
        case ({lq_push, lq_pop})
            2'b10:   lq_cnt_d = lq_cnt_q + CNT_ONE;
            2'b01:   lq_cnt_d = lq_cnt_q - CNT_ONE;
            default: lq_cnt_d = lq_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid_q  <= 1'b0;
            op_rdata1_q <= 32'd0;
            op_rdata2_q <= 32'd0;
            op_rd_q     <= 5'd0;
            busy_q      <= 32'd0;
            lq_cnt_q    <= '0;
            lq_wptr_q   <= '0;
            lq_rptr_q   <= '0;
        end else begin
            if (accept) begin
                op_valid_q  <= 1'b1;
                op_rdata1_q <= opnd1;
                op_rdata2_q <= opnd2;
                op_rd_q     <= bus.iss_wren ? bus.iss_rd : 5'd0;
            end else if (bus.op_ready) begin
                op_valid_q  <= 1'b0;
            end
            busy_q   <= busy_d;
            lq_cnt_q <= lq_cnt_d;
            if (lq_push) lq_wptr_q <= lq_wptr_q + PTR_ONE;
            if (lq_pop)  lq_rptr_q <= lq_rptr_q + PTR_ONE;
        end
    end

    // Queue payload is plain storage; validity comes from the reset-cleared count.
    always_ff @(posedge clk) begin
        if (lq_push) begin
            lq_addr_q[lq_wptr_q] <= bus.lng_wb_addr;
            lq_data_q[lq_wptr_q] <= bus.lng_wb_data;
        end
    end
endmodule

// File: tb/tb_reg_access.sv
// Randomized bench for reg_access: a register-level reference model predicts each cycle's
// write-port, handshake and operand results; a separate monitor pops and compares them.
module tb_reg_access;
    localparam int LQ_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n_cons = 0;

    reg_access_if bus ();

    reg_access #(.LQ_DEPTH(LQ_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Environment register file: combinational read, written by the DUT write port.
    logic [31:0] rf_mem [32];
    assign bus.rf_rdata1 = rf_mem[bus.rf_raddr1];
    assign bus.rf_rdata2 = rf_mem[bus.rf_raddr2];
    always @(posedge clk) if (bus.rf_wren && bus.rf_waddr != 5'd0) rf_mem[bus.rf_waddr] <= bus.rf_wdata;

    typedef struct {
        bit          hs;
        bit          iss_ready;
        bit          lng_ready;
        bit          op_valid;
        bit          wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } cyc_t;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
    } op_t;

    cyc_t cyc_q[$];
    op_t  op_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register values, pending destinations, FIFO of
    // long writebacks and an occupancy flag for the operand slot.
    initial begin
        logic [31:0] regs [32];
        bit          pending [32];
        logic [4:0]  lq_a[$];
        logic [31:0] lq_d[$];
        bit          out_full;
        cyc_t        c;
        op_t         o;
        bit          have, haz, acc;
        logic [4:0]  wa;
        logic [31:0] wd;
        regs[0] = 32'd0;
        rf_mem[0] <= 32'd0;
        for (int i = 1; i < 32; i++) begin
            regs[i] = $urandom;
            rf_mem[i] <= regs[i];
        end
        for (int i = 0; i < 32; i++) pending[i] = 1'b0;
        out_full = 1'b0;
        forever begin
            @(negedge clk);
            c = '{default: 0};
            if (rst) begin
                for (int i = 0; i < 32; i++) pending[i] = 1'b0;
                lq_a.delete();
                lq_d.delete();
                op_q.delete();
                out_full = 1'b0;
            end else begin
                c.hs        = 1'b1;
                c.lng_ready = (lq_a.size() < LQ_DEPTH);
                c.op_valid  = out_full;
                have = 1'b0;
                wa   = 5'd0;
                wd   = 32'd0;
                if (bus.alu_wb_valid) begin
                    have = 1'b1;
                    wa   = bus.alu_wb_addr;
                    wd   = bus.alu_wb_data;
                end else if (lq_a.size() > 0) begin
                    have = 1'b1;
                    wa   = lq_a.pop_front();
                    wd   = lq_d.pop_front();
                end
                c.wr    = have && (wa != 5'd0);
                c.waddr = wa;
                c.wdata = wd;
                haz = (bus.iss_rden1 && pending[bus.iss_rs1] && !(c.wr && wa == bus.iss_rs1)) ||
                      (bus.iss_rden2 && pending[bus.iss_rs2] && !(c.wr && wa == bus.iss_rs2)) ||
                      (bus.iss_wren  && pending[bus.iss_rd]  && !(c.wr && wa == bus.iss_rd));
                c.iss_ready = (!out_full || bus.op_ready) && !haz;
                acc = bus.iss_valid && c.iss_ready;
                if (c.wr) begin
                    regs[wa]    = wd;
                    pending[wa] = 1'b0;
                end
                if (out_full && bus.op_ready) out_full = 1'b0;
                if (acc) begin
                    o.d1 = bus.iss_rden1 ? regs[bus.iss_rs1] : 32'd0;
                    o.d2 = bus.iss_rden2 ? regs[bus.iss_rs2] : 32'd0;
                    o.rd = bus.iss_wren  ? bus.iss_rd : 5'd0;
                    op_q.push_back(o);
                    out_full = 1'b1;
                    if (bus.iss_wren && bus.iss_rd != 5'd0) pending[bus.iss_rd] = 1'b1;
                end
                if (bus.lng_wb_valid && c.lng_ready) begin
                    lq_a.push_back(bus.lng_wb_addr);
                    lq_d.push_back(bus.lng_wb_data);
                end
            end
            cyc_q.push_back(c);
        end
    end

    // Monitor: compares the DUT outputs of this cycle with the model's predictions.
    initial begin
        cyc_t c;
        op_t  o;
        forever begin
            @(negedge clk);
            #1;
            if (cyc_q.size() == 0) begin
                chk("cycle_queue_empty", 32'd1, 32'd0);
            end else begin
                c = cyc_q.pop_front();
                chk("rf_wren", {31'd0, bus.rf_wren}, {31'd0, c.wr});
                if (c.wr && bus.rf_wren) begin
                    chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, c.waddr});
                    chk("rf_wdata", bus.rf_wdata, c.wdata);
                end
                if (c.hs) begin
                    chk("iss_ready", {31'd0, bus.iss_ready}, {31'd0, c.iss_ready});
                    chk("lng_wb_ready", {31'd0, bus.lng_wb_ready}, {31'd0, c.lng_ready});
                    chk("op_valid", {31'd0, bus.op_valid}, {31'd0, c.op_valid});
                    if (bus.op_valid && bus.op_ready) begin
                        if (op_q.size() == 0) begin
                            chk("op_unexpected", 32'd1, 32'd0);
                        end else begin
                            o = op_q.pop_front();
                            chk("op_rdata1", bus.op_rdata1, o.d1);
                            chk("op_rdata2", bus.op_rdata2, o.d2);
                            chk("op_rd", {27'd0, bus.op_rd}, {27'd0, o.rd});
                            n_cons++;
                        end
                    end
                end
            end
        end
    end

    task automatic step(input bit iv, input bit e1, input int r1, input bit e2, input int r2,
                        input bit we, input int rd, input bit av, input int aa, input logic [31:0] ad,
                        input bit lv, input int la, input logic [31:0] ld, input bit ordy);
        bus.iss_valid    = iv;
        bus.iss_rden1    = e1;
        bus.iss_rs1      = 5'(r1);
        bus.iss_rden2    = e2;
        bus.iss_rs2      = 5'(r2);
        bus.iss_wren     = we;
        bus.iss_rd       = 5'(rd);
        bus.alu_wb_valid = av;
        bus.alu_wb_addr  = 5'(aa);
        bus.alu_wb_data  = ad;
        bus.lng_wb_valid = lv;
        bus.lng_wb_addr  = 5'(la);
        bus.lng_wb_data  = ld;
        bus.op_ready     = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic rand_phase(input int n, input int piss, input int palu, input int plng, input int prdy);
        for (int i = 0; i < n; i++)
            step(($urandom % 100) < piss, 1'($urandom), int'($urandom_range(0, 7)),
                 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
                 ($urandom % 100) < palu, int'($urandom_range(0, 7)), $urandom,
                 ($urandom % 100) < plng, int'($urandom_range(0, 7)), $urandom,
                 ($urandom % 100) < prdy);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_op_valid"}, {31'd0, bus.op_valid}, 32'd0);
        chk({tag, "_op_rdata1"}, bus.op_rdata1, 32'd0);
        chk({tag, "_op_rdata2"}, bus.op_rdata2, 32'd0);
        chk({tag, "_op_rd"}, {27'd0, bus.op_rd}, 32'd0);
        chk({tag, "_lng_wb_ready"}, {31'd0, bus.lng_wb_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.iss_valid = 0; bus.iss_rden1 = 0; bus.iss_rs1 = 0; bus.iss_rden2 = 0; bus.iss_rs2 = 0;
        bus.iss_wren = 0; bus.iss_rd = 0; bus.op_ready = 0;
        bus.alu_wb_valid = 0; bus.alu_wb_addr = 0; bus.alu_wb_data = 0;
        bus.lng_wb_valid = 0; bus.lng_wb_addr = 0; bus.lng_wb_data = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_checks("rst0");

        // Plain operand fetch, then RAW stall resolved by a same-cycle ALU writeback.
        step(1, 1, 5, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 7, 0, 0, 0, 0, 1, 7, 32'hAB, 0, 0, 0, 1);
        idle(2);
        // ALU wins the port; the long writeback lands a cycle later.
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h1, 1, 9, 32'h55, 1);
        idle(2);
        // Long writebacks back up behind a continuous ALU stream, then drain in order.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, i + 1, $urandom, 1, 10 + i, $urandom, 1);
        idle(4);
        // x0 as destination and source; ALU write to x0 is suppressed.
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 1);
        idle(2);
        // Execute back-pressure with a waiting instruction.
        step(1, 1, 2, 1, 3, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);

        rand_phase(400, 70, 40, 60, 70);
        rand_phase(300, 60, 85, 85, 80);
        rand_phase(200, 80, 30, 40, 20);

        // Reset mid-traffic with an ALU writeback presented during reset.
        step(1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 1, 6, 32'h77, 0);
        step(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 4, 32'h66, 0);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 1);
        rst = 1'b0;
        bus.alu_wb_valid = 0;
        reset_checks("rst1");

        rand_phase(300, 70, 50, 50, 60);
        idle(12);

        chk("op_queue_drained", op_q.size(), 32'd0);
        chk("ops_consumed_min", {31'd0, n_cons >= 50}, 32'd1);
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
